// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//
// Parametrised VGA timing generator with a built-in test-pattern engine for
// the TinyTapeout VGA PMOD (2 bits per colour channel). It produces the
// horizontal/vertical counters, the sync pulses and the data-enable. It also
// produces one of four runtime-selectable patterns. The pattern mode is
// latched only on the last clock of a frame, so a frame is never torn.
//
// Every output is registered from the current (h_cnt, v_cnt). The outputs
// therefore lag the counters by one clock and are mutually aligned.
//
// Optional feature macro: PATTERN_SCROLL_EN
//   When this macro is defined, an 8-bit scroll register advances once per
//   frame. The checker and gradient patterns then use x + scroll. The colour
//   bar index is rotated by scroll[7:5].
//
// Ports
//   i_CLK          pixel clock
//   i_RST_N        asynchronous active-low reset (released synchronously)
//   i_MODE[1:0]    pattern select: 0 solid, 1 colour bars, 2 checker,
//                  3 gradient (frame-latched)
//   i_COLOR[5:0]   solid colour {R,G,B} for mode 0 (sampled every clock)
//   o_HSYNC        horizontal sync, asserted level = SYNC_POL
//   o_VSYNC        vertical sync, asserted level = SYNC_POL
//   o_DE           active-video enable
//   o_R/o_G/o_B    2-bit colour channels, forced to 0 outside active video
//   o_X/o_Y        pixel column/row aligned with the other outputs
//   o_FRAME_START  one-cycle pulse presented together with pixel (0,0)
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CHK_SHIFT = 4,
    parameter int CW        = 10
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    input  logic [1:0]    i_MODE,
    input  logic [5:0]    i_COLOR,
    output logic          o_HSYNC,
    output logic          o_VSYNC,
    output logic          o_DE,
    output logic [1:0]    o_R,
    output logic [1:0]    o_G,
    output logic [1:0]    o_B,
    output logic [CW-1:0] o_X,
    output logic [CW-1:0] o_Y,
    output logic          o_FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          frame_last;
    logic [1:0]    mode_q;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] bar_sub;
    logic [2:0]    bar_n;
    logic [CW-1:0] x_pat;
    logic [2:0]    bar_idx;
    logic          active;
    logic          hs_win;
    logic          vs_win;
    logic [5:0]    pix;
    logic          unused_ok;

    assign h_last     = (h_cnt == H_LAST);
    assign frame_last = h_last && (v_cnt == V_LAST);

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Mode and frame counter only change at the frame boundary.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            mode_q    <= 2'd0;
            frame_cnt <= 8'd0;
        end else if (frame_last) begin
            mode_q    <= i_MODE;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Colour-bar index tracks h_cnt without a divider. A sub-counter walks
    // one bar width, and the index saturates at 7 so blanking stays on bar 7.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            bar_sub <= '0;
            bar_n   <= 3'd0;
        end else if (h_last) begin
            bar_sub <= '0;
            bar_n   <= 3'd0;
        end else if (bar_sub == BAR_LAST) begin
            bar_sub <= '0;
            if (bar_n != 3'd7) begin
                bar_n <= bar_n + 3'd1;
            end
        end else begin
            bar_sub <= bar_sub + 1'b1;
        end
    end

`ifdef PATTERN_SCROLL_EN
    logic [7:0] scroll;

    // Scroll offset advances once per frame, wrapping naturally at 8 bits.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            scroll <= 8'd0;
        end else if (frame_last) begin
            scroll <= scroll + 8'd1;
        end
    end

    assign x_pat   = h_cnt + CW'(scroll);
    assign bar_idx = bar_n + scroll[7:5];
`else
    assign x_pat   = h_cnt;
    assign bar_idx = bar_n;
`endif

    // Only a few bits of x_pat and frame_cnt feed the patterns.
    assign unused_ok = ^{frame_cnt[7:2], x_pat};

    // Pattern and timing decode for the current raster position.
    always_comb begin
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_win = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_win = (v_cnt >= VS_START) && (v_cnt < VS_END);
        pix    = 6'h00;
        unique case (mode_q)
            2'd0: pix = i_COLOR;
            2'd1: pix = {{2{bar_idx[2]}}, {2{bar_idx[1]}}, {2{bar_idx[0]}}};
            2'd2: pix = (x_pat[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]) ? 6'h3F : 6'h00;
            2'd3: pix = {x_pat[CHK_SHIFT+1:CHK_SHIFT],
                         v_cnt[CHK_SHIFT+1:CHK_SHIFT],
                         frame_cnt[1:0]};
            default: pix = 6'h00;
        endcase
        if (!active) begin
            pix = 6'h00;
        end
    end

    // Output register stage: everything leaves the block one clock after the
    // counters, so sync, DE, colour and coordinates stay aligned.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_HSYNC       <= ~SYNC_POL;
            o_VSYNC       <= ~SYNC_POL;
            o_DE          <= 1'b0;
            o_R           <= 2'd0;
            o_G           <= 2'd0;
            o_B           <= 2'd0;
            o_X           <= '0;
            o_Y           <= '0;
            o_FRAME_START <= 1'b0;
        end else begin
            o_HSYNC       <= hs_win ? SYNC_POL : ~SYNC_POL;
            o_VSYNC       <= vs_win ? SYNC_POL : ~SYNC_POL;
            o_DE          <= active;
            o_R           <= pix[5:4];
            o_G           <= pix[3:2];
            o_B           <= pix[1:0];
            o_X           <= h_cnt;
            o_Y           <= v_cnt;
            o_FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Bench for vga_pattern_gen using a small raster: H 16/2/3/3 (24 clocks),
// V 8/1/2/1 (12 lines), CHK_SHIFT = 1.
//
// The stimulus side pushes one expected output word per clock into a queue.
// A monitor pops one word per clock after the clock edge and compares it.
// The monitor also checks sync/DE run lengths, the frame period, and a table
// of hand-computed spot pixels.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] rgb;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } pix_t;

    typedef struct {
        int         f;
        int         x;
        int         y;
        logic [5:0] rgb;
        logic       de;
    } spot_t;

    localparam int NSP = 17;

`ifdef PATTERN_SCROLL_EN
    localparam logic [5:0] C9  = 6'h00;
    localparam logic [5:0] C10 = 6'h3F;
    localparam logic [5:0] C11 = 6'h00;
    localparam logic [5:0] C12 = 6'h18;
    localparam logic [5:0] C13 = 6'h3D;
    localparam logic [5:0] C14 = 6'h32;
    localparam logic [5:0] C16 = 6'h20;
`else
    localparam logic [5:0] C9  = 6'h3F;
    localparam logic [5:0] C10 = 6'h00;
    localparam logic [5:0] C11 = 6'h3F;
    localparam logic [5:0] C12 = 6'h38;
    localparam logic [5:0] C13 = 6'h1D;
    localparam logic [5:0] C14 = 6'h02;
    localparam logic [5:0] C16 = 6'h00;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [5:0] color;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;

    int    checks   = 0;
    int    failures = 0;
    pix_t  exp_q[$];
    spot_t spots[NSP];
    int    spot_hits = 0;

    int m_h;
    int m_v;
    int m_mode;
    int m_frame;
    int m_scroll;

    vga_pattern_gen #(
        .H_ACTIVE (16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE (8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL (1'b0), .CHK_SHIFT(1), .CW(10)
    ) dut (
        .i_CLK         (clk),
        .i_RST_N       (rst_n),
        .i_MODE        (mode),
        .i_COLOR       (color),
        .o_HSYNC       (hsync),
        .o_VSYNC       (vsync),
        .o_DE          (de),
        .o_R           (r),
        .o_G           (g),
        .o_B           (b),
        .o_X           (x),
        .o_Y           (y),
        .o_FRAME_START (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_hsync"}, 32'(hsync), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(vsync), 32'd1);
        checkOutput({tag, "_de"},    32'(de), 32'd0);
        checkOutput({tag, "_rgb"},   32'({r, g, b}), 32'd0);
        checkOutput({tag, "_x"},     32'(x), 32'd0);
        checkOutput({tag, "_y"},     32'(y), 32'd0);
        checkOutput({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    task automatic modelReset();
        m_h = 0; m_v = 0; m_mode = 0; m_frame = 0; m_scroll = 0;
    endtask

    // Drive the inputs, then run n clocks. Each clock pushes the output
    // expected for the pixel that the DUT registers on the next edge.
    task automatic applyStimulus(input logic [1:0] md, input logic [5:0] col,
                                 input int n);
        pix_t e;
        int   xe;
        int   bn;
        int   c;
        mode  = md;
        color = col;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xe = (m_h + m_scroll) % 1024;
            bn = m_h / 2;
            if (bn > 7) bn = 7;
            bn = (bn + (m_scroll >> 5)) % 8;
            e.de = (m_h < 16) && (m_v < 8);
            e.hs = (m_h >= 18 && m_h < 21) ? 1'b0 : 1'b1;
            e.vs = (m_v >= 9 && m_v < 11) ? 1'b0 : 1'b1;
            case (m_mode)
                0: c = int'(color);
                1: c = ((bn >> 2) & 1) * 48 + ((bn >> 1) & 1) * 12 + (bn & 1) * 3;
                2: c = (((xe >> 1) ^ (m_v >> 1)) & 1) != 0 ? 63 : 0;
                default: c = (((xe >> 1) & 3) << 4) | (((m_v >> 1) & 3) << 2) | (m_frame & 3);
            endcase
            e.rgb = e.de ? 6'(c) : 6'd0;
            e.x   = 10'(m_h);
            e.y   = 10'(m_v);
            e.fs  = (m_h == 0) && (m_v == 0);
            exp_q.push_back(e);
            if (m_h == 23) begin
                m_h = 0;
                if (m_v == 11) begin
                    m_v     = 0;
                    m_mode  = int'(mode);
                    m_frame = (m_frame + 1) % 256;
`ifdef PATTERN_SCROLL_EN
                    m_scroll = (m_scroll + 1) % 256;
`endif
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expectation per clock and compares. It also checks
    // line and frame timing and the hand-computed spot pixels.
    initial begin : monitor
        pix_t act;
        pix_t e;
        int   fidx = -1;
        int   hs_cnt = 0;
        int   de_cnt = 0;
        int   vs_cnt = 0;
        int   cyc = 0;
        int   last_fs = 0;
        bit   have_fs = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                hs_cnt = 0; de_cnt = 0; vs_cnt = 0; cyc = 0; have_fs = 0;
            end else if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {hsync, vsync, de, r, g, b, x, y, frame_start};
                checkOutput($sformatf("pix_x%0d_y%0d", e.x, e.y), 32'(act), 32'(e));
                if (frame_start) begin
                    fidx++;
                    if (have_fs) checkOutput("fs_period", 32'(cyc - last_fs), 32'd288);
                    have_fs = 1;
                    last_fs = cyc;
                end
                for (int i = 0; i < NSP; i++) begin
                    if (spots[i].f == fidx && spots[i].x == int'(x) && spots[i].y == int'(y)) begin
                        checkOutput($sformatf("spot%0d_rgb", i), 32'({r, g, b}), 32'(spots[i].rgb));
                        checkOutput($sformatf("spot%0d_de", i), 32'(de), 32'(spots[i].de));
                        spot_hits++;
                    end
                end
                if (!hsync) begin
                    hs_cnt++;
                    checkOutput("hsync_pos", 32'(x >= 10'd18 && x <= 10'd20), 32'd1);
                end
                if (de) de_cnt++;
                if (!vsync) vs_cnt++;
                if (x == 10'd23) begin
                    checkOutput("hsync_len", 32'(hs_cnt), 32'd3);
                    checkOutput("de_len", 32'(de_cnt), (y < 10'd8) ? 32'd16 : 32'd0);
                    hs_cnt = 0;
                    de_cnt = 0;
                    if (y == 10'd11) begin
                        checkOutput("vsync_len", 32'(vs_cnt), 32'd48);
                        vs_cnt = 0;
                    end
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        spots = '{
            '{0,  0, 0, 6'h2D, 1'b1},
            '{0, 16, 0, 6'h00, 1'b0},
            '{1,  0, 0, 6'h00, 1'b1},
            '{1,  2, 3, 6'h03, 1'b1},
            '{1,  4, 3, 6'h0C, 1'b1},
            '{1, 14, 0, 6'h3F, 1'b1},
            '{1, 16, 2, 6'h00, 1'b0},
            '{2,  3, 4, 6'h2D, 1'b1},
            '{2, 15, 7, 6'h15, 1'b1},
            '{3,  2, 0, C9,    1'b1},
            '{3,  2, 2, C10,   1'b1},
            '{3,  0, 2, C11,   1'b1},
            '{4,  6, 4, C12,   1'b1},
            '{5,  2, 6, C13,   1'b1},
            '{6,  0, 0, C14,   1'b1},
            '{7,  0, 0, 6'h2A, 1'b1},
            '{4,  0, 0, C16,   1'b1}
        };
        modelReset();
        mode  = 2'd1;
        color = 6'h2D;
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkReset("reset");

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(2'd1, 6'h2D, 288);  // frame 0 solid, bars latched
        applyStimulus(2'd1, 6'h2D, 150);  // frame 1 bars
        applyStimulus(2'd0, 6'h2D, 138);  // rest of frame 1, solid latched
        applyStimulus(2'd0, 6'h2D, 100);  // frame 2 solid
        applyStimulus(2'd2, 6'h15, 188);  // mid-frame switch: frame 2 stays solid
        applyStimulus(2'd2, 6'h15, 100);  // frame 3 checker
        applyStimulus(2'd3, 6'h15, 188);
        applyStimulus(2'd3, 6'h15, 288);  // frames 4 and 5 gradient
        applyStimulus(2'd3, 6'h15, 288);
        applyStimulus(2'd3, 6'h15, 128);  // frame 6 up to pixel (7,5)

        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #2;
        checkReset("midreset_hold");
        rst_n = 1'b1;
        applyStimulus(2'd0, 6'h2A, 30);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("spot_hits", 32'(spot_hits), 32'(NSP));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
